// File: rtl/fpu_wb_regif.sv
// Wishbone classic slave fronting the FPU: operand/mode/op registers, launch pulse,
// result/flag capture with a busy watchdog.
module fpu_wb_regif #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          OP_W      = 12,
    parameter logic [15:0] TIMEOUT   = 16'd1000
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    output logic [31:0]     a,
    output logic [31:0]     b,
    output logic [31:0]     c,
    output logic [2:0]      round_mode,
    output logic [OP_W-1:0] op_in,
    output logic            valid_in,
    input  logic [31:0]     fpu_result,
    input  logic [4:0]      fpu_flags,
    input  logic            fpu_out_valid,
    output logic            irq
);

    // state  | meaning
    // S_IDLE | no operation in flight; operand writes accepted, OP valid=1 launches
    // S_BUSY | FPU computing; operand writes discarded, watchdog counting down
    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t          state_q, state_d;
    logic [31:0]     a_q, a_d, b_q, b_d, c_q, c_d;
    logic [2:0]      rm_q, rm_d;
    logic [OP_W-1:0] op_q, op_d;
    logic [31:0]     result_q, result_d;
    logic [4:0]      flags_q, flags_d;
    logic            done_q, done_d, err_q, err_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic            valid_in_q, valid_in_d;
    logic            ack_q, ack_d;
    logic [31:0]     dat_o_q, dat_o_d;

    logic            hit, req, wr, rd, idle;
    logic [2:0]      idx;
    logic [31:0]     be_mask, lo_mask, rdata;
    logic [OP_W-1:0] op_mask, op_merged;
    logic            launch_bit;
    logic            unused_adr;

    function automatic logic [31:0] merge32(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    assign hit     = (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    assign req     = wbs_stb_i & wbs_cyc_i & hit & ~ack_q;
    assign wr      = req & wbs_we_i;
    assign rd      = req & ~wbs_we_i;
    assign idx     = wbs_adr_i[4:2];
    assign idle    = (state_q == S_IDLE);
    assign unused_adr = ^wbs_adr_i[1:0];

    assign be_mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    // Narrow control registers only listen on the low two byte lanes.
    assign lo_mask = {16'h0000, be_mask[15:0]};

    assign op_mask    = lo_mask[OP_W-1:0];
    assign op_merged  = (op_q & ~op_mask) | (wbs_dat_i[OP_W-1:0] & op_mask);
    assign launch_bit = wbs_dat_i[OP_W] & lo_mask[OP_W];

    always_comb begin
        rdata = 32'h0;
        case (idx)
            3'd0: rdata = a_q;
            3'd1: rdata = b_q;
            3'd2: rdata = c_q;
            3'd3: rdata = 32'(rm_q);
            3'd4: rdata = result_q;
            3'd5: rdata = 32'(flags_q);
            3'd6: rdata = {29'h0, err_q, done_q, ~idle};
            3'd7: rdata = 32'(op_q);
            default: rdata = 32'h0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        rm_d       = rm_q;
        op_d       = op_q;
        result_d   = result_q;
        flags_d    = flags_q;
        done_d     = done_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        pend_d     = 1'b0;
        valid_in_d = pend_q;
        ack_d      = req;
        dat_o_d    = rd ? rdata : 32'h0;

        if (wr) begin
            case (idx)
                3'd0: if (idle) a_d = merge32(a_q, wbs_dat_i, be_mask);
                3'd1: if (idle) b_d = merge32(b_q, wbs_dat_i, be_mask);
                3'd2: if (idle) c_d = merge32(c_q, wbs_dat_i, be_mask);
                3'd3: if (idle && wbs_sel_i[0]) rm_d = wbs_dat_i[2:0];
                3'd6: begin
                    if (wbs_sel_i[0] && wbs_dat_i[1]) begin
                        done_d = 1'b0;
                        err_d  = 1'b0;
                    end
                end
                3'd7: begin
                    if (idle) begin
                        op_d = op_merged;
                        if (launch_bit) begin
                            state_d = S_BUSY;
                            pend_d  = 1'b1;
                            cnt_d   = TIMEOUT;
                        end
                    end
                end
                default: ;
            endcase
        end

        // A completion in the same cycle as a done-clear write wins: it is newer.
        if (state_q == S_BUSY) begin
            if (fpu_out_valid) begin
                result_d = fpu_result;
                flags_d  = fpu_flags;
                done_d   = 1'b1;
                cnt_d    = 16'h0;
                state_d  = S_IDLE;
            end else if (cnt_q == 16'd1) begin
                err_d   = 1'b1;
                cnt_d   = 16'h0;
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q - 16'd1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            a_q        <= 32'h0;
            b_q        <= 32'h0;
            c_q        <= 32'h0;
            rm_q       <= 3'h0;
            op_q       <= '0;
            result_q   <= 32'h0;
            flags_q    <= 5'h0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= 16'h0;
            pend_q     <= 1'b0;
            valid_in_q <= 1'b0;
            ack_q      <= 1'b0;
            dat_o_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            rm_q       <= rm_d;
            op_q       <= op_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            valid_in_q <= valid_in_d;
            ack_q      <= ack_d;
            dat_o_q    <= dat_o_d;
        end
    end

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = dat_o_q;
    assign a          = a_q;
    assign b          = b_q;
    assign c          = c_q;
    assign round_mode = rm_q;
    assign op_in      = op_q;
    assign valid_in   = valid_in_q;
    assign irq        = done_q;

endmodule
